window_gen: RTL and testbench



---
 rtl/cnn_pkg.sv | 26 ++
 rtl/line_buf.sv | 34 +++
 rtl/window_gen.sv | 182 ++++++++++++++++++
 tb/tb_window_gen.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/cnn_pkg.sv
// rtl/cnn_pkg.sv - shared CNN constants, window FSM states and window slice indexing
//
// Purpose: definitions shared by window_gen, line_buf users and conv_layer.
// Contents:
//   DEFAULT_BIT_DEPTH - default pixel width
//   WIN_DIM / WIN_K   - window edge length and number of window taps
//   win_state_e       - window generator FSM state encodings
//   win_slice_lo()    - LSB of window tap k on the packed 9*BIT_DEPTH bus
package cnn_pkg;

    localparam int DEFAULT_BIT_DEPTH = 16;
    localparam int WIN_DIM           = 3;
    localparam int WIN_K             = WIN_DIM * WIN_DIM;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_DONE   = 2'd2
    } win_state_e;

    // Tap 0 (top-left) occupies the most significant slice, tap 8 the least.
    function automatic int win_slice_lo(input int k, input int bit_depth);
        return bit_depth * (WIN_K - 1 - k);
    endfunction

endpackage

// File: rtl/line_buf.sv
// rtl/line_buf.sv - single-port row buffer with same-cycle read-before-write
//
// Purpose: holds one image row, addressed by column.
// Ports:
//   clk      - clock
//   we_i     - write enable
//   addr_i   - column address (shared by read and write)
//   wdata_i  - write data
//   rdata_o  - asynchronous read of the currently addressed entry (old value
//              during a write cycle)
module line_buf #(
    parameter int DEPTH = 28,
    parameter int WIDTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we_i,
    input  logic [AW-1:0]    addr_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic [WIDTH-1:0] rdata_o
);

    // Contents are intentionally not reset; consumers gate stale data.
    logic [WIDTH-1:0] mem_q [DEPTH];

    assign rdata_o = mem_q[addr_i];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
    end

endmodule

// File: rtl/window_gen.sv
// rtl/window_gen.sv - raster pixel stream to 3x3 sliding window generator
//
// Purpose: builds stride-1, unpadded 3x3 windows from a row-major pixel
// stream using two line buffers and a 3x3 register array.
// Ports:
//   clk, RESET   - clock, synchronous active-high reset
//   frame_start  - pulse: arm or restart frame capture
//   pix_in       - pixel, raster order
//   pix_valid    - pix_in valid
//   win          - packed window, tap k at win[BIT_DEPTH*(9-k)-1 -: BIT_DEPTH]
//   win_valid    - one-cycle window qualifier
//   frame_done   - one-cycle pulse after the last pixel of a frame
module window_gen
    import cnn_pkg::*;
#(
    parameter int BIT_DEPTH = DEFAULT_BIT_DEPTH,
    parameter int IMG_W     = 28,
    parameter int IMG_H     = 28
) (
    input  logic                       clk,
    input  logic                       RESET,
    input  logic                       frame_start,
    input  logic [BIT_DEPTH-1:0]       pix_in,
    input  logic                       pix_valid,
    output logic [WIN_K*BIT_DEPTH-1:0] win,
    output logic                       win_valid,
    output logic                       frame_done
);

    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

    win_state_e state_q, state_d;
    logic [CW-1:0] col_q, col_d;
    logic [RW-1:0] row_q, row_d;

    logic          accept;
    logic [CW-1:0] acc_col;
    logic [RW-1:0] acc_row;
    logic          last_pix;
    logic          emit;

    logic [BIT_DEPTH-1:0] lb1_rd, lb2_rd;
    logic [BIT_DEPTH-1:0] arr_q [WIN_K];
    logic [BIT_DEPTH-1:0] arr_d [WIN_K];

    logic [WIN_K*BIT_DEPTH-1:0] win_q, win_d;
    logic                       win_valid_q;

    // A frame_start in the same cycle as pix_valid makes this pixel (0,0)
    // of the new frame, whatever state we are in.
    always_comb begin
        accept   = pix_valid && (frame_start || (state_q == ST_ACTIVE));
        acc_col  = frame_start ? '0 : col_q;
        acc_row  = frame_start ? '0 : row_q;
        last_pix = (acc_row == ROW_LAST) && (acc_col == COL_LAST);
        // Windows at columns 0/1 would straddle rows; rows 0/1 would
        // contain stale line-buffer data.
        emit     = accept && (acc_row >= RW'(2)) && (acc_col >= CW'(2));
    end

    // FSM: state register
    always_ff @(posedge clk) begin
        if (RESET) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   state_d = ST_IDLE;
            ST_ACTIVE: if (accept && last_pix) state_d = ST_DONE;
            ST_DONE:   state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
        // Restart wins over everything, including an in-progress frame.
        if (frame_start) begin
            state_d = ST_ACTIVE;
        end
    end

    // FSM: outputs
    always_comb begin
        frame_done = (state_q == ST_DONE);
    end

    // Counters wrap back to (0,0) on the last pixel so DONE/IDLE start clean.
    always_comb begin
        col_d = col_q;
        row_d = row_q;
        if (accept) begin
            if (acc_col == COL_LAST) begin
                col_d = '0;
                row_d = (acc_row == ROW_LAST) ? '0 : acc_row + RW'(1);
            end else begin
                col_d = acc_col + CW'(1);
                row_d = acc_row;
            end
        end else if (frame_start) begin
            col_d = '0;
            row_d = '0;
        end
    end

    // Shift window columns left; new right column is {lb2, lb1, pix_in}.
    always_comb begin
        for (int k = 0; k < WIN_K; k++) begin
            arr_d[k] = arr_q[k];
        end
        if (accept) begin
            for (int r = 0; r < WIN_DIM; r++) begin
                arr_d[WIN_DIM*r]     = arr_q[WIN_DIM*r + 1];
                arr_d[WIN_DIM*r + 1] = arr_q[WIN_DIM*r + 2];
            end
            arr_d[2] = lb2_rd;
            arr_d[5] = lb1_rd;
            arr_d[8] = pix_in;
        end
        win_d = '0;
        for (int k = 0; k < WIN_K; k++) begin
            win_d[win_slice_lo(k, BIT_DEPTH) +: BIT_DEPTH] = arr_d[k];
        end
    end

    always_ff @(posedge clk) begin
        if (RESET) begin
            col_q       <= '0;
            row_q       <= '0;
            win_q       <= '0;
            win_valid_q <= 1'b0;
            for (int k = 0; k < WIN_K; k++) begin
                arr_q[k] <= '0;
            end
        end else begin
            col_q       <= col_d;
            row_q       <= row_d;
            win_valid_q <= emit;
            // Output only updates on emitted windows so it holds otherwise.
            if (emit) begin
                win_q <= win_d;
            end
            for (int k = 0; k < WIN_K; k++) begin
                arr_q[k] <= arr_d[k];
            end
        end
    end

    assign win       = win_q;
    assign win_valid = win_valid_q;

    // lb1 holds row r-1, lb2 row r-2; lb2 is refilled from lb1's old value.
    line_buf #(
        .DEPTH (IMG_W),
        .WIDTH (BIT_DEPTH),
        .AW    (CW)
    ) u_lb1 (
        .clk     (clk),
        .we_i    (accept),
        .addr_i  (acc_col),
        .wdata_i (pix_in),
        .rdata_o (lb1_rd)
    );

    line_buf #(
        .DEPTH (IMG_W),
        .WIDTH (BIT_DEPTH),
        .AW    (CW)
    ) u_lb2 (
        .clk     (clk),
        .we_i    (accept),
        .addr_i  (acc_col),
        .wdata_i (lb1_rd),
        .rdata_o (lb2_rd)
    );

endmodule

// File: tb/tb_window_gen.sv
// tb/tb_window_gen.sv - directed self-checking bench for window_gen
module tb_window_gen;

    localparam int BD = 16;
    localparam int W  = 5;
    localparam int H  = 4;

    logic            clk = 1'b0;
    logic            RESET;
    logic            frame_start;
    logic [BD-1:0]   pix_in;
    logic            pix_valid;
    logic [9*BD-1:0] win;
    logic            win_valid;
    logic            frame_done;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    window_gen #(
        .BIT_DEPTH (BD),
        .IMG_W     (W),
        .IMG_H     (H)
    ) dut (
        .clk         (clk),
        .RESET       (RESET),
        .frame_start (frame_start),
        .pix_in      (pix_in),
        .pix_valid   (pix_valid),
        .win         (win),
        .win_valid   (win_valid),
        .frame_done  (frame_done)
    );

    // Window expected after accepting (r,c) when pixel = base + 10*r + c.
    function automatic logic [9*BD-1:0] exp_win(input int base, input int r, input int c);
        logic [9*BD-1:0] w;
        w = '0;
        for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 3; j++) begin
                w[BD*(9-(3*i+j))-1 -: BD] = BD'(base + 10*(r-2+i) + (c-2+j));
            end
        end
        return w;
    endfunction

    // Drive one cycle's inputs at the falling edge; return #1 after the rising edge.
    task automatic drive(input logic rst, input logic fs, input logic pv, input int px);
        @(negedge clk);
        RESET       = rst;
        frame_start = fs;
        pix_valid   = pv;
        pix_in      = BD'(px);
        @(posedge clk);
        #1;
    endtask

    task automatic run_frame(input string name, input int base, input bit gap,
                             input bit fs_on_first, output int n_win, output int n_fd);
        logic exp_v, exp_fd;
        n_win = 0;
        n_fd  = 0;
        if (!fs_on_first) begin
            drive(1'b0, 1'b1, 1'b0, 0);
            checks++;
            if (win_valid !== 1'b0) begin
                errors++;
                $display("FAIL %s start win_valid=%b expected 0", name, win_valid);
            end
        end
        for (int r = 0; r < H; r++) begin
            for (int c = 0; c < W; c++) begin
                drive(1'b0, fs_on_first && r == 0 && c == 0, 1'b1, base + 10*r + c);
                exp_v  = (r >= 2) && (c >= 2);
                exp_fd = (r == H-1) && (c == W-1);
                n_win += int'(win_valid);
                n_fd  += int'(frame_done);
                checks++;
                if (win_valid !== exp_v) begin
                    errors++;
                    $display("FAIL %s win_valid r=%0d c=%0d got %b expected %b", name, r, c, win_valid, exp_v);
                end
                if (exp_v) begin
                    checks++;
                    if (win !== exp_win(base, r, c)) begin
                        errors++;
                        $display("FAIL %s win r=%0d c=%0d got %h expected %h", name, r, c, win, exp_win(base, r, c));
                    end
                end
                checks++;
                if (frame_done !== exp_fd) begin
                    errors++;
                    $display("FAIL %s frame_done r=%0d c=%0d got %b expected %b", name, r, c, frame_done, exp_fd);
                end
                if (gap) begin
                    drive(1'b0, 1'b0, 1'b0, 0);
                    checks++;
                    if (win_valid !== 1'b0 || frame_done !== 1'b0) begin
                        errors++;
                        $display("FAIL %s gap r=%0d c=%0d win_valid=%b frame_done=%b expected 0 0", name, r, c, win_valid, frame_done);
                    end
                end
            end
        end
    endtask

    task automatic test_reset();
        drive(1'b1, 1'b0, 1'b0, 0);
        drive(1'b1, 1'b0, 1'b0, 0);
        checks++;
        if (win !== '0 || win_valid !== 1'b0 || frame_done !== 1'b0) begin
            errors++;
            $display("FAIL reset win=%h win_valid=%b frame_done=%b expected 0 0 0", win, win_valid, frame_done);
        end
    endtask

    task automatic test_idle_ignore();
        int nw, nf;
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 1'b0, 1'b1, 77 + i);
            checks++;
            if (win_valid !== 1'b0 || frame_done !== 1'b0) begin
                errors++;
                $display("FAIL idle_ignore win_valid=%b frame_done=%b expected 0 0", win_valid, frame_done);
            end
        end
        run_frame("idle_frame", 0, 1'b0, 1'b0, nw, nf);
        checks++;
        if (nw !== 6 || nf !== 1) begin
            errors++;
            $display("FAIL idle_counts windows=%0d done=%0d expected 6 1", nw, nf);
        end
    endtask

    task automatic test_continuous();
        int nw, nf;
        run_frame("continuous", 0, 1'b0, 1'b0, nw, nf);
        checks++;
        if (nw !== 6 || nf !== 1) begin
            errors++;
            $display("FAIL continuous_counts windows=%0d done=%0d expected 6 1", nw, nf);
        end
        // Back in IDLE: outputs quiet, win holds the last window.
        drive(1'b0, 1'b0, 1'b1, 999);
        checks++;
        if (win_valid !== 1'b0 || frame_done !== 1'b0 || win !== exp_win(0, 3, 4)) begin
            errors++;
            $display("FAIL hold win=%h win_valid=%b frame_done=%b expected %h 0 0", win, win_valid, frame_done, exp_win(0, 3, 4));
        end
    endtask

    task automatic test_toggle();
        int nw, nf;
        run_frame("toggle", 0, 1'b1, 1'b0, nw, nf);
        checks++;
        if (nw !== 6 || nf !== 1) begin
            errors++;
            $display("FAIL toggle_counts windows=%0d done=%0d expected 6 1", nw, nf);
        end
    endtask

    task automatic test_abort();
        int nw, nf;
        nf = 0;
        drive(1'b0, 1'b1, 1'b0, 0);
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < W; c++) begin
                if (r < 2 || c <= 3) begin
                    drive(1'b0, 1'b0, 1'b1, 10*r + c);
                    nf += int'(frame_done);
                end
            end
        end
        run_frame("abort_b", 100, 1'b0, 1'b0, nw, nf);
        checks++;
        if (nw !== 6 || nf !== 1) begin
            errors++;
            $display("FAIL abort_counts windows=%0d done=%0d expected 6 1", nw, nf);
        end
    endtask

    task automatic test_reset_mid();
        drive(1'b0, 1'b1, 1'b0, 0);
        for (int i = 0; i < 13; i++) begin
            drive(1'b0, 1'b0, 1'b1, 10*(i/W) + (i%W));
        end
        // Pixel (2,3) accepted together with RESET: its window is dropped.
        drive(1'b1, 1'b0, 1'b1, 23);
        checks++;
        if (win !== '0 || win_valid !== 1'b0 || frame_done !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid win=%h win_valid=%b frame_done=%b expected 0 0 0", win, win_valid, frame_done);
        end
        for (int i = 0; i < 6; i++) begin
            drive(1'b0, 1'b0, 1'b1, 24 + i);
            checks++;
            if (win !== '0 || win_valid !== 1'b0 || frame_done !== 1'b0) begin
                errors++;
                $display("FAIL reset_idle win=%h win_valid=%b frame_done=%b expected 0 0 0", win, win_valid, frame_done);
            end
        end
    endtask

    task automatic test_back_to_back();
        int nw1, nf1, nw2, nf2;
        run_frame("b2b_first", 0, 1'b0, 1'b0, nw1, nf1);
        run_frame("b2b_second", 200, 1'b0, 1'b1, nw2, nf2);
        checks++;
        if (nw1 + nw2 !== 12 || nf1 + nf2 !== 2) begin
            errors++;
            $display("FAIL b2b_counts windows=%0d done=%0d expected 12 2", nw1 + nw2, nf1 + nf2);
        end
    endtask

    initial begin
        RESET       = 1'b1;
        frame_start = 1'b0;
        pix_valid   = 1'b0;
        pix_in      = '0;
        test_reset();
        test_idle_ignore();
        test_continuous();
        test_toggle();
        test_abort();
        test_reset_mid();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
